buffer_ctrl: RTL

Parametrised synchronous FIFO; next generation of the team's single-clock load/consume stream buffer. Adds a generic depth and width, registered read data with a valid strobe, an occupancy count, programmable almost-full/almost-empty thresholds, an optional empty-FIFO bypass, and sticky overflow/underflow error flags. It sits between a producer asserting `load` and a consumer asserting `consume`, both in the same clock domain.

---
 rtl/buffer_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/buffer_ctrl.sv
// buffer_ctrl: single-clock stream FIFO between a producer (load) and a
// consumer (consume). Registered read data with a one-cycle valid strobe,
// occupancy count, almost-full/almost-empty thresholds, an optional
// empty-FIFO bypass and sticky overflow/underflow flags.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   load, data_in      write request and write data
//   consume            read request
//   data_out           registered read data, valid while data_valid=1
//   data_valid         one-cycle strobe per accepted consume (or bypass)
//   count              stored words, 0..DEPTH
//   empty/full         count==0 / count==DEPTH
//   almost_empty/full  count<=ae_level / count>=af_level
//   overflow/underflow sticky error flags, cleared only by rst
//
// state    | meaning
// ST_EMPTY | no words stored
// ST_RDY   | 1..DEPTH-1 words stored
// ST_FULL  | DEPTH words stored
module buffer_ctrl #(
    parameter int bit_width = 16,
    parameter int addr_len  = 3,
    parameter int af_level  = 2**addr_len - 1,
    parameter int ae_level  = 1,
    parameter int bypass_en = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 consume,
    input  logic [bit_width-1:0] data_in,
    output logic [bit_width-1:0] data_out,
    output logic                 data_valid,
    output logic [addr_len:0]    count,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_empty,
    output logic                 almost_full,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int DEPTH = 2**addr_len;
    localparam int CW    = addr_len + 1;

    typedef enum logic [1:0] {ST_EMPTY, ST_RDY, ST_FULL} state_t;

    state_t                state_q, state_d;
    logic [addr_len-1:0]   load_addr_q, load_addr_d;
    logic [addr_len-1:0]   consume_addr_q, consume_addr_d;
    logic [addr_len:0]     count_q, count_d;
    logic [bit_width-1:0]  data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  almost_empty_q, almost_empty_d;
    logic                  almost_full_q, almost_full_d;

    logic                  ld_acc, cs_acc, byp, ovf_evt, unf_evt;

    logic [bit_width-1:0]  mem [DEPTH];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: acceptance decisions from the registered state, next
    // count, and the state implied by that count.
    always_comb begin
        ld_acc  = 1'b0;
        cs_acc  = 1'b0;
        byp     = 1'b0;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                ld_acc = load;
                if (consume) begin
                    // Bypass replaces the store: the word goes straight out.
                    if (load && (bypass_en != 0)) begin
                        byp    = 1'b1;
                        ld_acc = 1'b0;
                    end else begin
                        unf_evt = 1'b1;
                    end
                end
            end
            ST_RDY: begin
                ld_acc = load;
                cs_acc = consume;
            end
            ST_FULL: begin
                cs_acc  = consume;
                ld_acc  = load && consume;
                ovf_evt = load && !consume;
            end
            default: ;
        endcase

        count_d = count_q;
        if (ld_acc && !cs_acc) begin
            count_d = count_q + CW'(1);
        end else if (cs_acc && !ld_acc) begin
            count_d = count_q - CW'(1);
        end

        if (count_d == '0) begin
            state_d = ST_EMPTY;
        end else if (count_d == CW'(DEPTH)) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_RDY;
        end
    end

    // Outputs and datapath next values.
    always_comb begin
        load_addr_d    = ld_acc ? load_addr_q + addr_len'(1) : load_addr_q;
        consume_addr_d = cs_acc ? consume_addr_q + addr_len'(1) : consume_addr_q;
        data_out_d     = data_out_q;
        if (byp) begin
            data_out_d = data_in;
        end else if (cs_acc) begin
            data_out_d = mem[consume_addr_q];
        end
        data_valid_d   = cs_acc || byp;
        overflow_d     = overflow_q || ovf_evt;
        underflow_d    = underflow_q || unf_evt;
        empty_d        = (count_d == '0);
        full_d         = (count_d == CW'(DEPTH));
        almost_empty_d = (count_d <= CW'(ae_level));
        almost_full_d  = (count_d >= CW'(af_level));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_addr_q    <= '0;
            consume_addr_q <= '0;
            count_q        <= '0;
            data_out_q     <= '0;
            data_valid_q   <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_empty_q <= 1'b1;
            almost_full_q  <= 1'b0;
        end else begin
            load_addr_q    <= load_addr_d;
            consume_addr_q <= consume_addr_d;
            count_q        <= count_d;
            data_out_q     <= data_out_d;
            data_valid_q   <= data_valid_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            empty_q        <= empty_d;
            full_q         <= full_d;
            almost_empty_q <= almost_empty_d;
            almost_full_q  <= almost_full_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && ld_acc) begin
            mem[load_addr_q] <= data_in;
        end
    end

    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign count        = count_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = almost_empty_q;
    assign almost_full  = almost_full_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
